// File: rtl/display_scan_ctrl.sv
// Purpose: time-multiplexes four 7-segment digit codes onto one segment bus plus four digit enables.
// Latency: outputs registered; a state change is visible one src_clk cycle after the edge that causes it.
// Backpressure: none; free-running scan while enable_i=1, all digits dark when enable_i=0.
//
// Ports:
//   src_clk_i      system clock
//   rst_i          asynchronous active-high reset
//   enable_i       scan enable; low forces all digits off and abandons the frame
//   segments_in_i  digit d code at [7d+6:7d], bit=1 means segment lit
//   blank_mask_i   bit d=1 keeps digit d dark during its slot (sampled live)
//   seg_out_o      shared segment bus, polarity per SEG_ACTIVE_LOW
//   an_out_o       digit enables, at most one active, polarity per AN_ACTIVE_LOW
//   digit_sel_o    index of the current slot
//   frame_done_o   one-cycle pulse when the scan wraps from digit 3 back to digit 0
module display_scan_ctrl #(
  parameter int DIGIT_TICKS    = 50000,
  parameter int BLANK_TICKS    = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        src_clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [27:0] segments_in_i,
  input  logic [3:0]  blank_mask_i,
  output logic [6:0]  seg_out_o,
  output logic [3:0]  an_out_o,
  output logic [1:0]  digit_sel_o,
  output logic        frame_done_o
);

  localparam int MAX_DB = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int MAX_T  = (MAX_DB > 2) ? MAX_DB : 2;
  localparam int CW     = $clog2(MAX_T);

  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? CW'(BLANK_TICKS - 1) : '0;
  localparam bit            NO_BLANK   = (BLANK_TICKS == 0);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [27:0]   snap_q, snap_d;
  logic          done_q, done_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic [6:0]    lit_code;
  logic [3:0]    an_onehot;

  // Next-state logic. With no dead time the SHOW slots chain directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    snap_d  = snap_q;
    done_d  = 1'b0;

    if (!enable_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sel_d   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = NO_BLANK ? S_SHOW : S_BLANK;
          cnt_d   = '0;
          sel_d   = 2'd0;
          snap_d  = segments_in_i;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SHOW: begin
          if (cnt_q == DIGIT_LAST) begin
            state_d = NO_BLANK ? S_SHOW : S_BLANK;
            cnt_d   = '0;
            sel_d   = sel_q + 2'd1;
            // Frame boundary: the only place fresh data is latched while running,
            // so a frame never mixes codes from two different input words.
            if (sel_q == 2'd3) begin
              done_d = 1'b1;
              snap_d = segments_in_i;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          sel_d   = 2'd0;
        end
      endcase
    end
  end

  // Pin drive is computed from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    lit_code  = snap_d[{3'd0, sel_d} * 5'd7 +: 7];
    an_onehot = 4'b0001 << sel_d;
    seg_d     = SEG_OFF;
    an_d      = AN_OFF;
    if (state_d == S_SHOW && !blank_mask_i[sel_d]) begin
      seg_d = SEG_ACTIVE_LOW ? ~lit_code : lit_code;
      an_d  = AN_ACTIVE_LOW  ? ~an_onehot : an_onehot;
    end
  end

  always_ff @(posedge src_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      snap_q  <= '0;
      done_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg_out_o    = seg_q;
  assign an_out_o     = an_q;
  assign digit_sel_o  = sel_q;
  assign frame_done_o = done_q;

endmodule
